// File: rtl/dot_accumulator_if.sv
// Product-in / result-out handshake bundle for the dot-product accumulator.
interface dot_accumulator_if #(
    parameter int P_WIDTH   = 64,
    parameter int ACC_WIDTH = 72,
    parameter int LEN_WIDTH = 8
);
    logic                        start;
    logic [LEN_WIDTH-1:0]        len;
    logic                        prod_valid;
    logic                        prod_ready;
    logic signed [P_WIDTH-1:0]   prod;
    logic                        result_valid;
    logic                        result_ready;
    logic signed [ACC_WIDTH-1:0] result;
    logic                        overflow;
    logic                        busy;

    modport master (
        output start, len, prod_valid, prod, result_ready,
        input  prod_ready, result_valid, result, overflow, busy
    );

    modport slave (
        input  start, len, prod_valid, prod, result_ready,
        output prod_ready, result_valid, result, overflow, busy
    );
endinterface

// File: rtl/dot_accumulator.sv
// Saturating accumulate stage behind the signed multiplier: sums a programmed
// number of signed products per job and hands out one result per job.
module dot_accumulator #(
    parameter int P_WIDTH   = 64,
    parameter int ACC_WIDTH = 72,
    parameter int LEN_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    dot_accumulator_if.slave io
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                      state;
    state_t                      state_next;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] result_q;
    logic                        ovf_q;
    logic [LEN_WIDTH-1:0]        count;
    logic signed [ACC_WIDTH:0]   sum_wide;
    logic signed [ACC_WIDTH-1:0] sum_sat;
    logic                        sum_clip;

    // The extra top bit keeps the true sum; top two bits differing means it left the range.
    function automatic logic signed [ACC_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH:0] s);
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
        return s[ACC_WIDTH-1:0];
    endfunction

    function automatic logic clipped(input logic signed [ACC_WIDTH:0] s);
        return s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
    endfunction

    // Sign-extended add of the incoming product, clamped per addition.
    always_comb begin
        sum_wide = {acc[ACC_WIDTH-1], acc}
                 + {{(ACC_WIDTH+1-P_WIDTH){io.prod[P_WIDTH-1]}}, io.prod};
        sum_sat  = saturate(sum_wide);
        sum_clip = clipped(sum_wide);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (io.start) state_next = (io.len != '0) ? ACCUM : DONE;
            ACCUM:   if (io.prod_valid && count == LEN_WIDTH'(1)) state_next = DONE;
            DONE:    if (io.result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Accumulator, product counter, result and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            count    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.start) begin
                        ovf_q <= 1'b0;
                        if (io.len != '0) begin
                            acc   <= '0;
                            count <= io.len;
                        end else begin
                            result_q <= '0;
                        end
                    end
                end
                ACCUM: begin
                    if (io.prod_valid) begin
                        acc   <= sum_sat;
                        count <= count - LEN_WIDTH'(1);
                        if (sum_clip) ovf_q <= 1'b1;
                        if (count == LEN_WIDTH'(1)) result_q <= sum_sat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.prod_ready   = (state == ACCUM);
    assign io.result_valid = (state == DONE);
    assign io.busy         = (state == ACCUM) || (state == DONE);
    assign io.result       = result_q;
    assign io.overflow     = ovf_q;
endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench: two accumulators (72-bit and 64-bit) share one stimulus stream.
module tb_dot_accumulator;
    logic               clk;
    logic               rst;
    logic               start;
    logic [7:0]         len;
    logic               prod_valid;
    logic signed [63:0] prod;
    logic               result_ready;

    int n_checks = 0;
    int n_fail   = 0;

    dot_accumulator_if #(.P_WIDTH(64), .ACC_WIDTH(72), .LEN_WIDTH(8)) a ();
    dot_accumulator_if #(.P_WIDTH(64), .ACC_WIDTH(64), .LEN_WIDTH(8)) b ();

    assign a.start = start;        assign b.start = start;
    assign a.len = len;            assign b.len = len;
    assign a.prod_valid = prod_valid; assign b.prod_valid = prod_valid;
    assign a.prod = prod;          assign b.prod = prod;
    assign a.result_ready = result_ready; assign b.result_ready = result_ready;

    dot_accumulator #(.P_WIDTH(64), .ACC_WIDTH(72), .LEN_WIDTH(8)) dut72 (
        .clk(clk), .rst(rst), .io(a.slave)
    );
    dot_accumulator #(.P_WIDTH(64), .ACC_WIDTH(64), .LEN_WIDTH(8)) dut64 (
        .clk(clk), .rst(rst), .io(b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [127:0] got,
                         input logic signed [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic signed [63:0] p);
        prod_valid = 1'b1;
        prod       = p;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic accept();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    localparam logic signed [63:0] BIG   = 64'sh3FFFFFFF00000001;
    localparam logic signed [63:0] P2_62 = 64'sh4000000000000000;
    localparam logic signed [63:0] N2_62 = 64'shC000000000000000;

    initial begin
        logic signed [71:0] exp72;
        rst = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0; result_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_prod_ready", a.prod_ready, 0);
        check("rst_result_valid", a.result_valid, 0);
        check("rst_busy", a.busy, 0);
        check("rst_result", a.result, 0);
        check("rst_overflow", a.overflow, 0);

        // Reset mid-job discards the partial sum.
        start_job(8'd4);
        check("mid_prod_ready", a.prod_ready, 1);
        feed(64'sd45);
        feed(64'sd56088);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_prod_ready", a.prod_ready, 0);
        check("mid_rst_result_valid", a.result_valid, 0);
        check("mid_rst_busy", a.busy, 0);
        check("mid_rst_result", a.result, 0);
        start_job(8'd1);
        feed(64'sd69);
        check("after_rst_valid", a.result_valid, 1);
        check("after_rst_result", a.result, 69);
        accept();

        // Basic back-to-back job.
        start_job(8'd3);
        check("basic_busy0", a.busy, 1);
        feed(-64'sd50);
        feed(64'sd45);
        check("basic_not_done", a.result_valid, 0);
        feed(64'sd42);
        check("basic_valid", a.result_valid, 1);
        check("basic_result", a.result, 37);
        check("basic_overflow", a.overflow, 0);
        check("basic_busy_done", a.busy, 1);
        accept();
        check("basic_idle_valid", a.result_valid, 0);
        check("basic_idle_busy", a.busy, 0);
        check("basic_result_held", a.result, 37);

        // Bubbles and backpressure.
        start_job(8'd2);
        feed(-64'sd797679);
        prod = 64'sd999;
        tick(); tick();
        check("bubble_still_accum", a.prod_ready, 1);
        check("bubble_no_result", a.result_valid, 0);
        feed(64'sd7006652);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", a.result_valid, 1);
            check("bp_result", a.result, 6208973);
            tick();
        end
        accept();
        check("bp_released", a.result_valid, 0);

        // Empty job.
        start_job(8'd0);
        check("empty_valid", a.result_valid, 1);
        check("empty_result", a.result, 0);
        check("empty_overflow", a.overflow, 0);
        accept();

        // start during ACCUM is ignored.
        start_job(8'd2);
        feed(64'sd10);
        start = 1'b1; len = 8'd5; tick(); start = 1'b0;
        feed(64'sd20);
        check("ign_start_valid", a.result_valid, 1);
        check("ign_start_result", a.result, 30);
        accept();

        // 255 large products: fits in 72 bits.
        start_job(8'd255);
        for (int i = 0; i < 255; i++) feed(BIG);
        exp72 = 72'sd255 * 72'sh003FFFFFFF00000001;
        check("sat72_valid", a.result_valid, 1);
        check("sat72_result", a.result, exp72);
        check("sat72_overflow", a.overflow, 0);
        accept();

        // Three large products: clamps at 64 bits, not at 72.
        start_job(8'd3);
        for (int i = 0; i < 3; i++) feed(BIG);
        check("sat64_result", b.result, 64'sh7FFFFFFFFFFFFFFF);
        check("sat64_overflow", b.overflow, 1);
        check("sat64_wide_result", a.result, 72'sh00BFFFFFFD00000003);
        check("sat64_wide_overflow", a.overflow, 0);
        accept();

        // Negative clamp then recovery off the rail.
        start_job(8'd4);
        check("neg_ovf_cleared", b.overflow, 0);
        feed(N2_62);
        feed(N2_62);
        check("neg_at_min_no_ovf", b.overflow, 0);
        feed(N2_62);
        check("neg_clamp_ovf", b.overflow, 1);
        feed(P2_62);
        check("neg_result", b.result, N2_62);
        check("neg_overflow_sticky", b.overflow, 1);
        check("neg_wide_result", a.result, 72'shFF8000000000000000);
        check("neg_wide_overflow", a.overflow, 0);
        accept();

        // Next job clears the sticky flag.
        start_job(8'd1);
        feed(64'sd5);
        check("clr_result", b.result, 5);
        check("clr_overflow", b.overflow, 0);
        accept();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
